// File: rtl/iic_pkg.sv
// Shared encodings and output decode for the single-shot I2C write master.
package iic_pkg;

  localparam int Q_W   = 2;
  localparam int BIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_ACK_WAIT = 3'd3,
    S_DATA     = 3'd4,
    S_STOP     = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Returns {scl, sda_low} for a given state, quarter and current shift MSB.
  function automatic logic [1:0] bus_drive(input state_t st, input logic [Q_W-1:0] q,
                                           input logic bit_val);
    logic scl_v;
    logic low_v;
    scl_v = 1'b1;
    low_v = 1'b0;
    case (st)
      S_START: low_v = q[1];
      S_ADDR, S_DATA: begin
        scl_v = q[1];
        low_v = ~bit_val;
      end
      S_ACK_WAIT: scl_v = q[1];
      S_STOP: begin
        scl_v = q[1];
        low_v = (q != 2'd3);
      end
      default: ;
    endcase
    return {scl_v, low_v};
  endfunction

endpackage

// File: rtl/iic_tick_gen.sv
// Clock divider producing a one-clk tick every CLK_DIV clocks and a quarter-bit counter.
module iic_tick_gen
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  output logic           tick,
  output logic [Q_W-1:0] q,
  output logic [Q_W-1:0] q_next
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  assign tick   = (div == DIV_LAST);
  // Quarters only advance while a bit is on the wire, so START always begins at q=0.
  assign q_next = (tick && run) ? q + 2'd1 : q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
      q   <= '0;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      q   <= q_next;
    end
  end

endmodule

// File: rtl/iic_controller.sv
// Single-shot I2C master write: START, address+W, ACK, data, ACK, STOP, then park in DONE.
module iic_controller
  import iic_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] slave_addr,
  input  logic [7:0] data,
  output logic       sda,
  output logic       scl
);

  localparam logic [2:0] ACK_WAIT = 3'd3;
  localparam logic [2:0] DONE     = 3'd6;

  state_t           state, state_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       data_lat, data_lat_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic             phase, phase_n;
  logic             sda_low;
  logic [1:0]       drive_n;
  logic             tick, run, last_q;
  logic [Q_W-1:0]   q, q_next;

  assign run    = (state != S_IDLE) && (state != DONE);
  assign last_q = (q == 2'd3);

  iic_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .tick   (tick),
    .q      (q),
    .q_next (q_next)
  );

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    data_lat_n = data_lat;
    bit_cnt_n  = bit_cnt;
    phase_n    = phase;
    if (tick) begin
      case (state)
        S_IDLE: begin
          state_n    = S_START;
          shift_n    = {slave_addr, 1'b0};
          data_lat_n = data;
          bit_cnt_n  = '0;
          phase_n    = 1'b0;
        end
        S_START: if (last_q) state_n = S_ADDR;
        S_ADDR, S_DATA: begin
          if (last_q) begin
            if (bit_cnt == 3'd7) begin
              state_n   = S_ACK_WAIT;
              bit_cnt_n = '0;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
              shift_n   = {shift[6:0], 1'b0};
            end
          end
        end
        ACK_WAIT: begin
          // ACK is never sampled; the phase flag alone picks data or stop.
          if (last_q) begin
            if (!phase) begin
              state_n = S_DATA;
              shift_n = data_lat;
              phase_n = 1'b1;
            end else begin
              state_n = S_STOP;
            end
          end
        end
        S_STOP: if (last_q) state_n = S_DONE;
        default: state_n = state;
      endcase
    end
    drive_n = bus_drive(state_n, q_next, shift_n[7]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      shift    <= '0;
      data_lat <= '0;
      bit_cnt  <= '0;
      phase    <= 1'b0;
      scl      <= 1'b1;
      sda_low  <= 1'b0;
    end else if (tick) begin
      state    <= state_n;
      shift    <= shift_n;
      data_lat <= data_lat_n;
      bit_cnt  <= bit_cnt_n;
      phase    <= phase_n;
      scl      <= drive_n[1];
      sda_low  <= drive_n[0];
    end
  end

  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_controller.sv
// Bench for iic_controller: pull-up bus model, slave ACK model and SDA bit scoreboard.
module tb_iic_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] slave_addr = 7'h42;
  logic [7:0] data = 8'hAA;
  logic       scl;
  wire        sda_w;
  logic       slave_low = 1'b0;

  pullup (sda_w);
  assign sda_w = slave_low ? 1'b0 : 1'bz;

  iic_controller #(.CLK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .slave_addr (slave_addr),
    .data       (data),
    .sda        (sda_w),
    .scl        (scl)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];
  int   rise_cnt = 0;
  int   start_cnt = 0;
  int   stop_cnt = 0;
  bit   mon_en = 1'b0;
  bit   ack_addr = 1'b0;
  bit   ack_data = 1'b0;
  logic prev_scl = 1'b1;
  logic prev_sda = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_txn(input logic [6:0] a, input logic [7:0] d,
                          input bit aa, input bit ad);
    logic [7:0] ab;
    ab = {a, 1'b0};
    for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
    exp_q.push_back(aa ? 1'b0 : 1'b1);
    for (int i = 7; i >= 0; i--) exp_q.push_back(d[i]);
    exp_q.push_back(ad ? 1'b0 : 1'b1);
    exp_q.push_back(1'b0);
  endtask

  // SDA sampled at every SCL rise against the scoreboard.
  always begin
    logic e;
    @(posedge scl);
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) check("extra_scl_rise", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check($sformatf("bit%0d", rise_cnt), sda_w, e);
      end
      rise_cnt++;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (mon_en) begin
      if (prev_scl && scl && prev_sda && !sda_w) start_cnt++;
      if (prev_scl && scl && !prev_sda && sda_w) stop_cnt++;
    end
    prev_scl = scl;
    prev_sda = sda_w;
  end

  // Slave pulls SDA low through the ACK low phase and lets go at the next SCL fall.
  always begin
    @(negedge scl);
    if (mon_en && ((rise_cnt == 8 && ack_addr) || (rise_cnt == 17 && ack_data)))
      slave_low = 1'b1;
    else
      slave_low = 1'b0;
  end

  task automatic run_to_done(input string tag, input bit change_inputs);
    for (int n = 1; n <= 162; n++) begin
      @(posedge clk);
      #1;
      if (change_inputs && n == 4) begin
        slave_addr = 7'h7F;
        data = 8'h00;
      end
      if (n == 161) check({tag, "_pre_done"}, (dut.state == 3'd6), 32'd0);
      if (n == 162) check({tag, "_done_162"}, dut.state, 32'd6);
    end
  endtask

  task automatic clear_mon();
    exp_q.delete();
    rise_cnt = 0;
    start_cnt = 0;
    stop_cnt = 0;
    slave_low = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst_scl", scl, 32'd1);
      check("rst_sda", sda_w, 32'd1);
      check("rst_state", dut.state, 32'd0);
    end

    // Transaction 1: 0x42 / 0xAA, slave acks address only; inputs change after latch.
    ack_addr = 1'b1;
    ack_data = 1'b0;
    clear_mon();
    push_txn(7'h42, 8'hAA, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    run_to_done("t1", 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      check("t1_stable", {dut.state, scl, sda_w}, {3'd6, 1'b1, 1'b1});
    end
    check("t1_bits_left", exp_q.size(), 32'd0);
    check("t1_start", start_cnt, 32'd1);
    check("t1_stop", stop_cnt, 32'd1);

    // Transaction 2: 0x3C / 0x5A, aborted mid-DATA by reset.
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b0;
    slave_addr = 7'h3C;
    data = 8'h5A;
    @(negedge clk);
    ack_addr = 1'b1;
    ack_data = 1'b1;
    clear_mon();
    push_txn(7'h3C, 8'h5A, 1'b1, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    begin
      int guard;
      guard = 0;
      while (rise_cnt < 12 && guard < 400) begin
        @(posedge clk);
        #2;
        guard++;
      end
      check("t2_reach_data", (rise_cnt >= 12), 32'd1);
    end
    check("t2_in_data", dut.state, 32'd4);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_scl", scl, 32'd1);
    check("abort_sda", sda_w, 32'd1);
    check("abort_state", dut.state, 32'd0);
    mon_en = 1'b0;
    @(negedge clk);
    clear_mon();
    push_txn(7'h3C, 8'h5A, 1'b1, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    run_to_done("t3", 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("t3_bits_left", exp_q.size(), 32'd0);
    check("t3_start", start_cnt, 32'd1);
    check("t3_stop", stop_cnt, 32'd1);
    check("t3_idle_bus", {scl, sda_w}, {1'b1, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
